bert_run_ctrl: RTL and testbench



---
 rtl/bert_pkg.sv | 20 ++
 rtl/bert_run_ctrl_if.sv | 40 ++++
 rtl/bert_run_ctrl_sat_accum.sv | 25 ++
 rtl/bert_run_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_bert_run_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/bert_pkg.sv
// Shared types and constants for the BERT run sequencer.
package bert_pkg;

   localparam int ERR_W_DEF = 32;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_RESET_EXT  = 3'd1,
      ST_WAIT_ALIGN = 3'd2,
      ST_SETTLE     = 3'd3,
      ST_MEASURE    = 3'd4,
      ST_DONE       = 3'd5
   } state_e;

   localparam logic [1:0] FAIL_NONE    = 2'd0;
   localparam logic [1:0] FAIL_TIMEOUT = 2'd1;
   localparam logic [1:0] FAIL_LOCK    = 2'd2;
   localparam logic [1:0] FAIL_ABORT   = 2'd3;

endpackage

// File: rtl/bert_run_ctrl_if.sv
// Control/status bundle between the run sequencer and its host/extractor.
interface bert_run_ctrl_if
   import bert_pkg::*;
#(
   parameter int ERR_W = ERR_W_DEF
);
   logic             start;
   logic             abort;
   logic [31:0]      window_len;
   logic [23:0]      align_timeout;
   logic [3:0]       max_retries;
   logic             aligned;
   logic [9:0]       align_addr;
   logic [6:0]       error_count_in;
   logic             ext_reset;
   logic             busy;
   logic             done;
   logic             pass;
   logic [1:0]       fail_code;
   logic [2:0]       state;
   logic [3:0]       retry_count;
   logic [7:0]       lock_lost_count;
   logic [9:0]       captured_addr;
   logic [ERR_W-1:0] cycles_run;
   logic [ERR_W-1:0] err_total;

   modport master (
      output start, abort, window_len, align_timeout, max_retries,
             aligned, align_addr, error_count_in,
      input  ext_reset, busy, done, pass, fail_code, state, retry_count,
             lock_lost_count, captured_addr, cycles_run, err_total
   );

   modport slave (
      input  start, abort, window_len, align_timeout, max_retries,
             aligned, align_addr, error_count_in,
      output ext_reset, busy, done, pass, fail_code, state, retry_count,
             lock_lost_count, captured_addr, cycles_run, err_total
   );
endinterface

// File: rtl/bert_run_ctrl_sat_accum.sv
// Saturating accumulator register with synchronous clear and enable.
module sat_accum #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr_i,
   input  logic         en_i,
   input  logic [W-1:0] addend_i,
   output logic [W-1:0] q_o
);
   logic [W-1:0] acc_q;
   logic [W:0]   sum_d;

   assign sum_d = {1'b0, acc_q} + {1'b0, addend_i};
   assign q_o   = acc_q;

   always_ff @(posedge clk) begin
      if (reset || clr_i) begin
         acc_q <= '0;
      end else if (en_i) begin
         acc_q <= sum_d[W] ? '1 : sum_d[W-1:0];
      end
   end
endmodule

// File: rtl/bert_run_ctrl.sv
// Run sequencer: extractor reset, alignment wait, settle, BER window, retry.
//   state      | meaning
//   IDLE       | never run since reset
//   RESET_EXT  | extractor held in reset for RST_CYCLES
//   WAIT_ALIGN | waiting for aligned, optional timeout
//   SETTLE     | aligned, errors ignored for SETTLE_CYCLES
//   MEASURE    | accumulating errors over the window
//   DONE       | result valid
module bert_run_ctrl
   import bert_pkg::*;
#(
   parameter int RST_CYCLES    = 8,
   parameter int SETTLE_CYCLES = 16,
   parameter int ERR_W         = ERR_W_DEF
) (
   input  logic           clk,
   input  logic           reset,
   bert_run_ctrl_if.slave bus
);
   localparam int TMR_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam logic [TMR_W-1:0] TMR_RST    = TMR_W'(RST_CYCLES - 1);
   localparam logic [TMR_W-1:0] TMR_SETTLE = TMR_W'(SETTLE_CYCLES - 1);
   localparam int CW = (ERR_W > 32) ? ERR_W : 32;

   state_e           state_q;
   logic [TMR_W-1:0] tmr_q;
   logic [23:0]      wait_q, tmo_q;
   logic [31:0]      win_q;
   logic [3:0]       max_q, retry_q;
   logic [ERR_W-1:0] cycles_q;
   logic [9:0]       addr_q;
   logic             ext_reset_q, busy_q, done_q, pass_q;
   logic [1:0]       fail_q;
   logic [ERR_W-1:0] err_total;
   logic [7:0]       lock_lost;

   logic       active, start_ok, abort_ok, retry_req, win_done, err_en, lock_en;
   logic [1:0] retry_cause;

   assign active   = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign start_ok = bus.start && !active;
   assign abort_ok = bus.abort && active;
   assign err_en   = (state_q == ST_MEASURE) && bus.aligned && !abort_ok;
   assign lock_en  = (state_q == ST_MEASURE) && !bus.aligned && !abort_ok;
   // Compare in a width that holds both the window and the run counter.
   assign win_done = (CW'(cycles_q) + CW'(1)) == CW'(win_q);

   always_comb begin
      retry_req   = 1'b0;
      retry_cause = FAIL_NONE;
      case (state_q)
         ST_WAIT_ALIGN: begin
            if (!bus.aligned && (tmo_q != 24'd0) && ((wait_q + 24'd1) == tmo_q)) begin
               retry_req   = 1'b1;
               retry_cause = FAIL_TIMEOUT;
            end
         end
         ST_SETTLE, ST_MEASURE: begin
            if (!bus.aligned) begin
               retry_req   = 1'b1;
               retry_cause = FAIL_LOCK;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         ext_reset_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_q      <= FAIL_NONE;
         tmr_q       <= '0;
         wait_q      <= '0;
         tmo_q       <= '0;
         win_q       <= '0;
         max_q       <= '0;
         retry_q     <= '0;
         cycles_q    <= '0;
         addr_q      <= '0;
      end else if (abort_ok) begin
         state_q     <= ST_DONE;
         ext_reset_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b1;
         pass_q      <= 1'b0;
         fail_q      <= FAIL_ABORT;
      end else if (retry_req) begin
         if (retry_q < max_q) begin
            retry_q     <= retry_q + 4'd1;
            state_q     <= ST_RESET_EXT;
            ext_reset_q <= 1'b1;
            tmr_q       <= TMR_RST;
            wait_q      <= '0;
         end else begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= 1'b0;
            fail_q  <= retry_cause;
         end
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (bus.start) begin
                  state_q     <= ST_RESET_EXT;
                  ext_reset_q <= 1'b1;
                  tmr_q       <= TMR_RST;
                  wait_q      <= '0;
                  busy_q      <= 1'b1;
                  done_q      <= 1'b0;
                  pass_q      <= 1'b0;
                  fail_q      <= FAIL_NONE;
                  win_q       <= (bus.window_len == 32'd0) ? 32'd1 : bus.window_len;
                  tmo_q       <= bus.align_timeout;
                  max_q       <= bus.max_retries;
                  retry_q     <= '0;
                  cycles_q    <= '0;
               end
            end
            ST_RESET_EXT: begin
               if (tmr_q == '0) begin
                  state_q     <= ST_WAIT_ALIGN;
                  ext_reset_q <= 1'b0;
                  wait_q      <= '0;
               end else begin
                  tmr_q <= tmr_q - 1'b1;
               end
            end
            ST_WAIT_ALIGN: begin
               if (bus.aligned) begin
                  state_q <= ST_SETTLE;
                  tmr_q   <= TMR_SETTLE;
               end else begin
                  wait_q <= wait_q + 24'd1;
               end
            end
            ST_SETTLE: begin
               if (tmr_q == '0) begin
                  state_q <= ST_MEASURE;
                  addr_q  <= bus.align_addr;
               end else begin
                  tmr_q <= tmr_q - 1'b1;
               end
            end
            ST_MEASURE: begin
               cycles_q <= cycles_q + 1'b1;
               if (win_done) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  // Saturating add of non-negative terms is zero only if both are zero.
                  pass_q  <= (err_total == '0) && (bus.error_count_in == 7'd0);
                  fail_q  <= FAIL_NONE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   sat_accum #(.W(ERR_W)) u_err_acc (
      .clk      (clk),
      .reset    (reset),
      .clr_i    (start_ok),
      .en_i     (err_en),
      .addend_i (ERR_W'(bus.error_count_in)),
      .q_o      (err_total)
   );

   sat_accum #(.W(8)) u_lock_acc (
      .clk      (clk),
      .reset    (reset),
      .clr_i    (start_ok),
      .en_i     (lock_en),
      .addend_i (8'd1),
      .q_o      (lock_lost)
   );

   assign bus.ext_reset       = ext_reset_q;
   assign bus.busy            = busy_q;
   assign bus.done            = done_q;
   assign bus.pass            = pass_q;
   assign bus.fail_code       = fail_q;
   assign bus.state           = state_q;
   assign bus.retry_count     = retry_q;
   assign bus.lock_lost_count = lock_lost;
   assign bus.captured_addr   = addr_q;
   assign bus.cycles_run      = cycles_q;
   assign bus.err_total       = err_total;
endmodule

// File: tb/tb_bert_run_ctrl.sv
// Directed bench for bert_run_ctrl: clean run, errors, timeout, lock loss, abort, saturation.
module tb_bert_run_ctrl;
   import bert_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   nchk = 0;
   int   npass = 0;

   always #5 clk = ~clk;

   bert_run_ctrl_if bus ();
   bert_run_ctrl_if #(.ERR_W(8)) b8 ();

   bert_run_ctrl dut (.clk(clk), .reset(reset), .bus(bus.slave));
   bert_run_ctrl #(.ERR_W(8)) dut8 (.clk(clk), .reset(reset), .bus(b8.slave));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      if (obs === exp) npass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_st(input logic [2:0] st, input int max_cyc, input string tag);
      int n = 0;
      while (bus.state !== st && n < max_cyc) begin
         tick();
         n++;
      end
      chk(tag, 32'(bus.state), 32'(st));
   endtask

   task automatic run_to_measure(input logic [31:0] win, input logic [23:0] tmo,
                                 input logic [3:0] mr, input logic [6:0] settle_err);
      bus.aligned       = 1'b0;
      bus.window_len    = win;
      bus.align_timeout = tmo;
      bus.max_retries   = mr;
      bus.start         = 1'b1;
      tick();
      bus.start = 1'b0;
      wait_st(ST_WAIT_ALIGN, 20, "reach_wait");
      repeat (4) tick();
      bus.aligned = 1'b1;
      wait_st(ST_SETTLE, 5, "reach_settle");
      bus.error_count_in = settle_err;
      wait_st(ST_MEASURE, 30, "reach_measure");
      bus.error_count_in = 7'd0;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int n;
      int pulses;
      logic prev;

      bus.start = 0; bus.abort = 0; bus.window_len = 0; bus.align_timeout = 0;
      bus.max_retries = 0; bus.aligned = 0; bus.align_addr = 10'h2A5; bus.error_count_in = 0;
      b8.start = 0; b8.abort = 0; b8.window_len = 0; b8.align_timeout = 0;
      b8.max_retries = 0; b8.aligned = 0; b8.align_addr = 0; b8.error_count_in = 0;
      repeat (3) tick();

      chk("rst_state", 32'(bus.state), 0);
      chk("rst_ext", 32'(bus.ext_reset), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_fail", 32'(bus.fail_code), 0);
      chk("rst_err", bus.err_total, 0);
      chk("rst_addr", 32'(bus.captured_addr), 0);
      reset = 1'b0;
      tick();

      // Clean run with explicit timing counts
      bus.window_len = 100; bus.align_timeout = 1000; bus.max_retries = 0;
      bus.start = 1; tick(); bus.start = 0;
      chk("clean_busy", 32'(bus.busy), 1);
      n = 0;
      while (bus.ext_reset === 1'b1 && n < 50) begin n++; tick(); end
      chk("clean_ext_len", n, 8);
      chk("clean_wait", 32'(bus.state), 32'(ST_WAIT_ALIGN));
      repeat (4) tick();
      bus.aligned = 1; tick();
      n = 0;
      while (bus.state === ST_SETTLE && n < 50) begin n++; tick(); end
      chk("clean_settle_len", n, 16);
      chk("clean_measure", 32'(bus.state), 32'(ST_MEASURE));
      chk("clean_addr", 32'(bus.captured_addr), 32'h2A5);
      bus.align_addr = 10'h011;
      wait_st(ST_DONE, 200, "clean_done_st");
      chk("clean_pass", 32'(bus.pass), 1);
      chk("clean_fail", 32'(bus.fail_code), 0);
      chk("clean_cycles", bus.cycles_run, 100);
      chk("clean_err", bus.err_total, 0);
      chk("clean_addr_hold", 32'(bus.captured_addr), 32'h2A5);

      // Errors counted; SETTLE errors ignored
      run_to_measure(20, 0, 0, 7'd5);
      bus.error_count_in = 3;
      repeat (4) tick();
      bus.error_count_in = 0;
      wait_st(ST_DONE, 40, "err_done_st");
      chk("err_total", bus.err_total, 12);
      chk("err_pass", 32'(bus.pass), 0);
      chk("err_fail", 32'(bus.fail_code), 0);
      chk("err_cycles", bus.cycles_run, 20);

      // window_len 0 behaves as 1
      run_to_measure(0, 0, 0, 7'd0);
      wait_st(ST_DONE, 5, "win0_done_st");
      chk("win0_cycles", bus.cycles_run, 1);
      chk("win0_pass", 32'(bus.pass), 1);

      // Align timeout with two retries
      bus.aligned = 0; bus.align_timeout = 50; bus.max_retries = 2;
      bus.start = 1; tick(); bus.start = 0;
      pulses = bus.ext_reset ? 1 : 0;
      prev = bus.ext_reset;
      n = 0;
      while (bus.done !== 1'b1 && n < 1000) begin
         tick();
         n++;
         if (bus.ext_reset && !prev) pulses++;
         prev = bus.ext_reset;
      end
      chk("tmo_done", 32'(bus.done), 1);
      chk("tmo_pulses", pulses, 3);
      chk("tmo_fail", 32'(bus.fail_code), 1);
      chk("tmo_retry", 32'(bus.retry_count), 2);
      chk("tmo_pass", 32'(bus.pass), 0);

      // Lock loss at MEASURE cycle 40, recovered on retry
      run_to_measure(100, 0, 1, 7'd0);
      repeat (39) tick();
      chk("lock_cyc39", bus.cycles_run, 39);
      bus.aligned = 0; tick();
      chk("lock_state", 32'(bus.state), 32'(ST_RESET_EXT));
      chk("lock_cnt", 32'(bus.lock_lost_count), 1);
      chk("lock_retry", 32'(bus.retry_count), 1);
      chk("lock_cyc_keep", bus.cycles_run, 39);
      wait_st(ST_WAIT_ALIGN, 20, "lock_wait");
      repeat (4) tick();
      bus.aligned = 1;
      wait_st(ST_DONE, 200, "lock_done_st");
      chk("lock_pass", 32'(bus.pass), 1);
      chk("lock_fail", 32'(bus.fail_code), 0);
      chk("lock_cycles", bus.cycles_run, 100);
      chk("lock_cnt_end", 32'(bus.lock_lost_count), 1);

      // Abort during WAIT_ALIGN together with start
      bus.aligned = 0; bus.align_timeout = 0; bus.max_retries = 0;
      bus.start = 1; tick(); bus.start = 0;
      wait_st(ST_WAIT_ALIGN, 20, "abort_wait");
      bus.abort = 1; bus.start = 1; tick(); bus.abort = 0; bus.start = 0;
      chk("abort_state", 32'(bus.state), 32'(ST_DONE));
      chk("abort_fail", 32'(bus.fail_code), 3);
      chk("abort_ext", 32'(bus.ext_reset), 0);
      chk("abort_busy", 32'(bus.busy), 0);
      bus.abort = 1; tick(); bus.abort = 0;
      chk("abort_done_ign", 32'(bus.fail_code), 3);
      bus.start = 1; tick(); bus.start = 0;
      chk("restart_state", 32'(bus.state), 32'(ST_RESET_EXT));
      chk("restart_fail", 32'(bus.fail_code), 0);
      chk("restart_done", 32'(bus.done), 0);
      chk("restart_cycles", bus.cycles_run, 0);
      chk("restart_lock", 32'(bus.lock_lost_count), 0);
      bus.abort = 1; tick(); bus.abort = 0;
      chk("abort_rst_ext", 32'(bus.ext_reset), 0);
      chk("abort_rst_state", 32'(bus.state), 32'(ST_DONE));

      // Reset mid-run
      bus.start = 1; tick(); bus.start = 0;
      repeat (3) tick();
      reset = 1; tick(); reset = 0;
      chk("midrst_state", 32'(bus.state), 0);
      chk("midrst_ext", 32'(bus.ext_reset), 0);
      chk("midrst_busy", 32'(bus.busy), 0);
      chk("midrst_done", 32'(bus.done), 0);

      // Saturation on the 8-bit instance
      b8.aligned = 1; b8.window_len = 32'hFFFF_FFFF; b8.error_count_in = 7'd127;
      b8.start = 1; tick(); b8.start = 0;
      n = 0;
      while (b8.state !== ST_MEASURE && n < 60) begin tick(); n++; end
      chk("sat_measure", 32'(b8.state), 32'(ST_MEASURE));
      repeat (2) tick();
      chk("sat_254", 32'(b8.err_total), 254);
      tick();
      chk("sat_255", 32'(b8.err_total), 255);
      repeat (5) tick();
      chk("sat_hold", 32'(b8.err_total), 255);
      b8.abort = 1; tick(); b8.abort = 0;
      chk("sat_abort", 32'(b8.fail_code), 3);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end
endmodule
